// File: rtl/camera_stream_gen_pkg.sv
// Shared definitions for camera_stream_gen: pattern modes, FSM states and LFSR constants.
// The HBLANK/VBLANK states exist only when CAMERA_BLANKING_EN is defined.
package camera_stream_gen_pkg;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 (1-based), i.e. bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

`ifdef CAMERA_BLANKING_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;
`else
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;
`endif

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/camera_stream_gen_if.sv
// Pixel stream bus: valid/ready handshake, packed multi-channel data and frame markers.
interface camera_stream_gen_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 1
) ();
    logic                     data_valid;
    logic                     data_ready;
    logic [N_CH*DATA_W-1:0]   data_out;
    logic                     sof;
    logic                     eol;
    logic                     eof;

    modport master (
        output data_valid,
        output data_out,
        output sof,
        output eol,
        output eof,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data_out,
        input  sof,
        input  eol,
        input  eof,
        output data_ready
    );
endinterface

// File: rtl/camera_stream_gen_lfsr.sv
// 16-bit Fibonacci LFSR; steps once per accepted pixel and is reset to the seed.
module camera_stream_gen_lfsr
    import camera_stream_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/camera_stream_gen.sv
// Synthetic camera source: IMG_W x IMG_H frames with SOF/EOL/EOF; CAMERA_BLANKING_EN adds H/V blanking.
// First beat one cycle after camera_en; with data_ready low all outputs hold and x/y/LFSR freeze.
module camera_stream_gen
    import camera_stream_gen_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              N_CH      = 1,
    parameter int              IMG_W     = 8,
    parameter int              IMG_H     = 8,
    parameter logic [DATA_W-1:0] CONST_VAL = '0,
    parameter int              CHK_LOG2  = 2,
    parameter int              FCNT_W    = 8
`ifdef CAMERA_BLANKING_EN
    ,
    parameter int              H_BLANK   = 4,
    parameter int              V_BLANK   = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               camera_en,
    input  logic [1:0]         mode,
    camera_stream_gen_if.master bus,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               busy
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);

    state_t                 state;
    state_t                 state_nxt;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [1:0]             mode_q;
    logic [15:0]            lfsr;
    logic                   active;
    logic                   xfer;
    logic                   last_x;
    logic                   last_y;
    logic                   start_frame;
    logic [DATA_W-1:0]      pix;
    logic [31:0]            chk;
    logic [N_CH*DATA_W-1:0] dout;

    assign active = (state == ST_ACTIVE);
    assign xfer   = active & bus.data_ready;
    assign last_x = (x == X_W'(IMG_W - 1));
    assign last_y = (y == Y_W'(IMG_H - 1));

`ifdef CAMERA_BLANKING_EN
    logic [15:0] blank_cnt;
    logic        blank_done;

    assign blank_done = ((state == ST_HBLANK) && (blank_cnt == 16'(H_BLANK - 1))) ||
                        ((state == ST_VBLANK) && (blank_cnt == 16'(V_BLANK - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_cnt <= '0;
        end else if (state_nxt != state) begin
            blank_cnt <= '0;
        end else if ((state == ST_HBLANK) || (state == ST_VBLANK)) begin
            blank_cnt <= blank_cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // camera_en is only consulted between frames, so a frame always runs to eof
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (camera_en) begin
                    state_nxt   = ST_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (xfer && last_x) begin
                    if (last_y) begin
`ifdef CAMERA_BLANKING_EN
                        state_nxt = ST_VBLANK;
`else
                        if (camera_en) begin
                            start_frame = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
`endif
                    end
`ifdef CAMERA_BLANKING_EN
                    else begin
                        state_nxt = ST_HBLANK;
                    end
`endif
                end
            end
`ifdef CAMERA_BLANKING_EN
            ST_HBLANK: begin
                if (blank_done) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_VBLANK: begin
                if (blank_done) begin
                    if (camera_en) begin
                        state_nxt   = ST_ACTIVE;
                        start_frame = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            mode_q    <= MODE_CONST;
        end else begin
            if (start_frame) begin
                mode_q <= mode;
            end
            if (xfer) begin
                if (last_x) begin
                    x <= '0;
                    if (last_y) begin
                        y         <= '0;
                        frame_cnt <= frame_cnt + FCNT_W'(1);
                    end else begin
                        y <= y + Y_W'(1);
                    end
                end else begin
                    x <= x + X_W'(1);
                end
            end
        end
    end

    camera_stream_gen_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (xfer),
        .lfsr (lfsr)
    );

    always_comb begin
        chk = ((32'(x) ^ 32'(y)) >> CHK_LOG2) & 32'd1;
        case (mode_q)
            MODE_CONST: pix = CONST_VAL;
            MODE_RAMP:  pix = DATA_W'(32'(x) + 32'(y));
            MODE_CHECK: pix = (chk != 32'd0) ? '1 : '0;
            default:    pix = DATA_W'(lfsr);
        endcase

        dout = '0;
        if (active) begin
            for (int c = 0; c < N_CH; c++) begin
                dout[c*DATA_W +: DATA_W] = pix + DATA_W'(c);
            end
        end

        bus.data_valid = active;
        bus.data_out   = dout;
        bus.sof        = active && (x == '0) && (y == '0);
        bus.eol        = active && last_x;
        bus.eof        = active && last_x && last_y;
        busy           = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_camera_stream_gen.sv
// Bench for camera_stream_gen (4x2 frames, 2 channels): directed tables plus a randomized run
// checked every cycle against a frame/beat-index reference model.
module tb_camera_stream_gen;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       camera_en;
    logic [1:0] mode;
    logic [2:0] frame_cnt;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    camera_stream_gen_if #(.DATA_W(8), .N_CH(2)) bus ();

    camera_stream_gen #(
        .DATA_W    (8),
        .N_CH      (2),
        .IMG_W     (W),
        .IMG_H     (H),
        .CONST_VAL (8'h5A),
        .CHK_LOG2  (1),
        .FCNT_W    (3)
`ifdef CAMERA_BLANKING_EN
        ,
        .H_BLANK   (4),
        .V_BLANK   (16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .camera_en (camera_en),
        .mode      (mode),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_lfsr_step(input logic [15:0] l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return 16'((int'(l) * 2 + fb) % 65536);
    endfunction

    // Two-channel pixel word for beat index k of a frame
    function automatic logic [15:0] ref_pix(input int k, input int md, input logic [15:0] l);
        int px, py, p;
        px = k % W;
        py = k / W;
        case (md)
            0:       p = 'h5A;
            1:       p = px + py;
            2:       p = (((px / 2) + (py / 2)) % 2 == 1) ? 255 : 0;
            default: p = int'(l) % 256;
        endcase
        return 16'((((p + 1) % 256) * 256) + (p % 256));
    endfunction

`ifndef CAMERA_BLANKING_EN
    bit          m_active;
    int          m_beat;
    int          m_mode;
    int          m_frames;
    logic [15:0] m_lfsr;

    // Inputs change just after posedge, so at negedge they are the values the next edge will use
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_beat   = 0;
            m_frames = 0;
            m_lfsr   = 16'hACE1;
            check("rst_valid", bus.data_valid, 0);
        end else begin
            check("mon_valid", bus.data_valid, m_active);
            check("mon_busy", busy, m_active);
            check("mon_fcnt", frame_cnt, m_frames % 8);
            check("mon_data", bus.data_out, m_active ? ref_pix(m_beat, m_mode, m_lfsr) : 16'h0);
            check("mon_sof", bus.sof, m_active && m_beat == 0);
            check("mon_eol", bus.eol, m_active && (m_beat % W) == W - 1);
            check("mon_eof", bus.eof, m_active && m_beat == NPIX - 1);
            if (!m_active) begin
                if (camera_en) begin
                    m_active = 1'b1;
                    m_beat   = 0;
                    m_mode   = int'(mode);
                end
            end else if (bus.data_ready) begin
                m_lfsr = ref_lfsr_step(m_lfsr);
                if (m_beat == NPIX - 1) begin
                    m_frames++;
                    m_beat = 0;
                    if (camera_en) m_mode = int'(mode);
                    else           m_active = 1'b0;
                end else begin
                    m_beat++;
                end
            end
        end
    end
`endif

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } vec_t;

    vec_t       tbl [NPIX];
    logic [7:0] chk_row [W];
    int         n;
    int         gap;
    int         gaps [$];

    initial begin
        tbl = '{'{8'h00, 1'b1, 1'b0, 1'b0}, '{8'h01, 1'b0, 1'b0, 1'b0},
                '{8'h02, 1'b0, 1'b0, 1'b0}, '{8'h03, 1'b0, 1'b1, 1'b0},
                '{8'h01, 1'b0, 1'b0, 1'b0}, '{8'h02, 1'b0, 1'b0, 1'b0},
                '{8'h03, 1'b0, 1'b0, 1'b0}, '{8'h04, 1'b0, 1'b1, 1'b1}};
        chk_row = '{8'h00, 8'h00, 8'hFF, 8'hFF};

        rst = 1'b1; camera_en = 1'b0; mode = 2'd0; bus.data_ready = 1'b1;
        repeat (2) step();
        check("reset_valid", bus.data_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_fcnt", frame_cnt, 0);
        check("reset_data", bus.data_out, 0);
        rst = 1'b0;

`ifdef CAMERA_BLANKING_EN
        camera_en = 1'b1; mode = 2'd1;
        gap = 0;
        step();
        for (int c = 0; c < 60; c++) begin
            if (bus.data_valid) begin
                if (gap > 0) gaps.push_back(gap);
                gap = 0;
            end else begin
                gap++;
            end
            step();
        end
        check("blank_runs", gaps.size() >= 2, 1);
        if (gaps.size() >= 2) begin
            check("hblank_len", gaps[0], 4);
            check("vblank_len", gaps[1], 16);
        end
`else
        // Ramp frame with ready held high
        camera_en = 1'b1; mode = 2'd1;
        step();
        for (int i = 0; i < NPIX; i++) begin
            check("ramp_ch0", bus.data_out[7:0], tbl[i].pix);
            check("ramp_ch1", bus.data_out[15:8], (int'(tbl[i].pix) + 1) % 256);
            check("ramp_sof", bus.sof, tbl[i].sof);
            check("ramp_eol", bus.eol, tbl[i].eol);
            check("ramp_eof", bus.eof, tbl[i].eof);
            step();
        end
        check("ramp_fcnt", frame_cnt, 1);
        check("ramp_next_sof", bus.sof, 1);

        // Alternating ready: same sequence of accepted pixels
        n = 0;
        for (int c = 0; c < 40 && n < NPIX; c++) begin
            bus.data_ready = (c % 2 == 0);
            if (bus.data_valid && bus.data_ready) begin
                check("toggle_pix", bus.data_out[7:0], tbl[n].pix);
                check("toggle_eol", bus.eol, tbl[n].eol);
                n++;
            end
            step();
        end
        bus.data_ready = 1'b1;
        check("toggle_count", n, NPIX);

        // camera_en dropped at beat 2: frame still completes
        rst = 1'b1; step(); rst = 1'b0;
        camera_en = 1'b1; mode = 2'd1;
        repeat (3) step();
        check("en_drop_beat2", bus.data_out[7:0], 2);
        camera_en = 1'b0;
        repeat (6) step();
        check("en_drop_valid", bus.data_valid, 0);
        check("en_drop_busy", busy, 0);
        check("en_drop_fcnt", frame_cnt, 1);

        // Mode change mid-frame takes effect only at the next sof
        rst = 1'b1; step(); rst = 1'b0;
        camera_en = 1'b1; mode = 2'd0;
        step();
        mode = 2'd2;
        for (int i = 0; i < NPIX; i++) begin
            check("const_frame", bus.data_out[7:0], 8'h5A);
            step();
        end
        for (int i = 0; i < W; i++) begin
            check("check_row0", bus.data_out[7:0], chk_row[i]);
            step();
        end

        // Asynchronous reset in the second LFSR frame
        rst = 1'b1; step(); rst = 1'b0;
        camera_en = 1'b1; mode = 2'd3;
        repeat (12) step();
        check("pre_rst_fcnt", frame_cnt, 1);
        #2 rst = 1'b1;
        #1;
        check("async_valid", bus.data_valid, 0);
        check("async_data", bus.data_out, 0);
        check("async_busy", busy, 0);
        check("async_fcnt", frame_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("reseed_data", bus.data_out, 16'hE2E1);
        check("reseed_sof", bus.sof, 1);
        step();
        check("reseed_next", bus.data_out[7:0], ref_lfsr_step(16'hACE1) % 256);

        // Randomized traffic; every cycle is checked by the negedge model
        for (int c = 0; c < 3000; c++) begin
            bus.data_ready = ($urandom_range(0, 3) != 0);
            camera_en      = ($urandom_range(0, 7) != 0);
            mode           = 2'($urandom_range(0, 3));
            step();
        end
`endif
        camera_en = 1'b0;
        bus.data_ready = 1'b1;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
